div_unit: RTL

//  Multi-cycle 32/32 radix-2 restoring divider serving the EX stage's DIV/DIVU

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
// EX is the master: it drives the operands and start/annul, and the
// divider (slave) answers with the packed result and ready flag.
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                   signed_div_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic                   start_i;
  logic                   annul_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Divides operand magnitudes one bit per clock, then fixes up signs.
// The result is packed {remainder, quotient}, so EX writes HI = remainder
// and LO = quotient.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     clk,
  input logic     rst,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  // One restoring step: shift {rem, dividend} left, trial-subtract divisor.
  // The dividend register fills up with quotient bits from the bottom.
  logic [WIDTH+1:0]   shifted;
  logic [WIDTH+1:0]   trial;
  logic               q_bit;
  logic [WIDTH:0]     rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes; negating 0x80000000 yields 0x80000000, which is the
  // right magnitude when read as unsigned.
  logic               op1_neg, op2_neg;
  logic [WIDTH-1:0]   mag1, mag2;

  assign shifted  = {1'b0, rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {2'b00, dvs_q};
  assign q_bit    = ~trial[WIDTH+1];
  assign rem_step = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_step = {dvd_q[WIDTH-2:0], q_bit};
  assign quo_fix  = (s1_q ^ s2_q) ? -quo_step : quo_step;
  assign rem_fix  = s1_q ? -rem_step[WIDTH-1:0] : rem_step[WIDTH-1:0];

  assign op1_neg  = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign op2_neg  = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign mag1     = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2     = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

  // Next-state and datapath update for the FREE/BYZERO/ON/END sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      S_FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i != '0) begin
            dvd_d   = mag1;
            dvs_d   = mag2;
            rem_d   = '0;
            s1_d    = op1_neg;
            s2_d    = op2_neg;
            cnt_d   = '0;
            state_d = S_ON;
          end else begin
            state_d = S_BYZERO;
          end
        end
      end

      S_BYZERO: begin
        if (bus.annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          state_d  = S_END;
          ready_d  = 1'b1;
          result_d = '0;
        end
      end

      S_ON: begin
        if (bus.annul_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          rem_d = rem_step;
          dvd_d = quo_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
            state_d  = S_END;
          end
        end
      end

      S_END: begin
        if (!bus.start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end

      default: begin
        state_d  = S_FREE;
        ready_d  = 1'b0;
        result_d = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

endmodule
